// File: rtl/count_sequence_checker.sv
// Sequence monitor for an up/down counter bus sampled on rising edges of a divided clock.
// Infers direction, locks onto a +/-1 sequence, and reports illegal steps and step statistics.
module count_sequence_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8,
    parameter int STEP_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              clk_d,
    input  logic [WIDTH-1:0]  counter,
    output logic              dir,
    output logic              locked,
    output logic              err,
    output logic              dir_chg,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [STEP_W-1:0] step_cnt,
    output logic [WIDTH-1:0]  last_val
);

    typedef enum logic [1:0] {
        EMPTY,
        ACQ,
        TRACK
    } state_t;

    localparam logic [2:0]       LOCK_TGT = 3'(LOCK_CNT);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t              state, state_nxt;
    logic                clk_d_q;
    logic                smp;
    logic [WIDTH-1:0]    delta;
    logic                step_up, step_dn, step_ok;
    logic [2:0]          cons, cons_nxt, cons_inc;
    logic                cand, cand_nxt;
    logic                dir_nxt, locked_nxt, err_nxt, dir_chg_nxt;
    logic [ERR_W-1:0]    err_cnt_nxt;
    logic [STEP_W-1:0]   step_cnt_nxt;
    logic [WIDTH-1:0]    last_val_nxt;

    assign smp     = clk_d & ~clk_d_q;
    assign delta   = counter - last_val;
    assign step_up = (delta == ONE);
    assign step_dn = (delta == '1);
    assign step_ok = step_up | step_dn;

    // A step that disagrees with the running candidate restarts the consistency run at 1.
    assign cons_inc = ((cons == 3'd0) || (step_up == cand)) ? cons + 3'd1 : 3'd1;

    always_comb begin
        state_nxt    = state;
        cons_nxt     = cons;
        cand_nxt     = cand;
        dir_nxt      = dir;
        locked_nxt   = locked;
        err_nxt      = 1'b0;
        dir_chg_nxt  = 1'b0;
        err_cnt_nxt  = err_cnt;
        step_cnt_nxt = step_cnt;
        last_val_nxt = last_val;

        if (smp) begin
            last_val_nxt = counter;
            unique case (state)
                EMPTY: begin
                    state_nxt = ACQ;
                end
                ACQ: begin
                    if (step_ok) begin
                        cand_nxt = step_up;
                        cons_nxt = cons_inc;
                        // The step that completes acquisition is itself a valid locked step.
                        if (cons_inc == LOCK_TGT) begin
                            state_nxt    = TRACK;
                            dir_nxt      = step_up;
                            locked_nxt   = 1'b1;
                            step_cnt_nxt = step_cnt + STEP_W'(1);
                        end
                    end else begin
                        cons_nxt = 3'd0;
                    end
                end
                TRACK: begin
                    if (step_ok) begin
                        step_cnt_nxt = step_cnt + STEP_W'(1);
                        if (step_up != dir) begin
                            dir_nxt     = step_up;
                            dir_chg_nxt = 1'b1;
                        end
                    end else begin
                        err_nxt    = 1'b1;
                        locked_nxt = 1'b0;
                        cons_nxt   = 3'd0;
                        state_nxt  = ACQ;
                        if (err_cnt != '1) begin
                            err_cnt_nxt = err_cnt + ERR_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Clear wins over a coincident sample, so the sample never reaches last_val.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= EMPTY;
            clk_d_q  <= 1'b0;
            cons     <= 3'd0;
            cand     <= 1'b0;
            dir      <= 1'b0;
            locked   <= 1'b0;
            err      <= 1'b0;
            dir_chg  <= 1'b0;
            err_cnt  <= '0;
            step_cnt <= '0;
            last_val <= '0;
        end else if (clr) begin
            state    <= EMPTY;
            clk_d_q  <= 1'b0;
            cons     <= 3'd0;
            cand     <= 1'b0;
            dir      <= 1'b0;
            locked   <= 1'b0;
            err      <= 1'b0;
            dir_chg  <= 1'b0;
            err_cnt  <= '0;
            step_cnt <= '0;
            last_val <= '0;
        end else begin
            state    <= state_nxt;
            clk_d_q  <= clk_d;
            cons     <= cons_nxt;
            cand     <= cand_nxt;
            dir      <= dir_nxt;
            locked   <= locked_nxt;
            err      <= err_nxt;
            dir_chg  <= dir_chg_nxt;
            err_cnt  <= err_cnt_nxt;
            step_cnt <= step_cnt_nxt;
            last_val <= last_val_nxt;
        end
    end

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench for count_sequence_checker: vector table for up/reversal/illegal runs,
// hand sequences for error saturation, async reset and synchronous clear.
module tb_count_sequence_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        clk_d;
    logic [3:0]  counter;
    logic        dir, locked, err, dir_chg;
    logic [7:0]  err_cnt;
    logic [15:0] step_cnt;
    logic [3:0]  last_val;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [3:0]  val;
        int          low;
        logic        e_dir;
        logic        e_locked;
        logic        e_err;
        logic        e_chg;
        logic [7:0]  e_ec;
        logic [15:0] e_sc;
    } vec_t;

    vec_t vecs[$];

    count_sequence_checker #(
        .WIDTH(4), .LOCK_CNT(2), .ERR_W(8), .STEP_W(16)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .clk_d(clk_d), .counter(counter),
        .dir(dir), .locked(locked), .err(err), .dir_chg(dir_chg),
        .err_cnt(err_cnt), .step_cnt(step_cnt), .last_val(last_val)
    );

    always #5 clk = ~clk;

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // clk_d low for 'low' cycles, then high for one; returns at the negedge after the sampling edge
    task automatic applyStimulus(input logic [3:0] v, input int low);
        repeat (low) @(negedge clk);
        counter = v;
        clk_d   = 1'b1;
        @(negedge clk);
        clk_d   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkField({tag, ".dir"},      32'(dir),      32'(v.e_dir));
        checkField({tag, ".locked"},   32'(locked),   32'(v.e_locked));
        checkField({tag, ".err"},      32'(err),      32'(v.e_err));
        checkField({tag, ".dir_chg"},  32'(dir_chg),  32'(v.e_chg));
        checkField({tag, ".err_cnt"},  32'(err_cnt),  32'(v.e_ec));
        checkField({tag, ".step_cnt"}, 32'(step_cnt), 32'(v.e_sc));
        checkField({tag, ".last_val"}, 32'(last_val), 32'(v.val));
    endtask

    task automatic addVec(input logic [3:0] val, input int low, input logic d, input logic l,
                          input logic e, input logic c, input logic [7:0] ec, input logic [15:0] sc);
        vec_t v;
        v.val = val; v.low = low; v.e_dir = d; v.e_locked = l;
        v.e_err = e; v.e_chg = c; v.e_ec = ec; v.e_sc = sc;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] cur;
        logic [7:0] exp_ec;

        // up count 0..15,0,1 with clk_d period 4; lock after 3rd sample, locking step counted
        addVec(4'd0, 3, 0, 0, 0, 0, 0, 0);
        addVec(4'd1, 3, 0, 0, 0, 0, 0, 0);
        for (int i = 2; i < 18; i++) begin
            addVec(4'(i % 16), 3, 1, 1, 0, 0, 0, 16'(i - 1));
        end
        // climb to 6, then reverse at 5
        addVec(4'd2, 1, 1, 1, 0, 0, 0, 17);
        addVec(4'd3, 1, 1, 1, 0, 0, 0, 18);
        addVec(4'd4, 1, 1, 1, 0, 0, 0, 19);
        addVec(4'd5, 1, 1, 1, 0, 0, 0, 20);
        addVec(4'd6, 1, 1, 1, 0, 0, 0, 21);
        addVec(4'd5, 1, 0, 1, 0, 1, 0, 22);
        addVec(4'd4, 1, 0, 1, 0, 0, 0, 23);
        // back to locked-up at 3, then illegal jump to 7 and relock at 9
        addVec(4'd3, 1, 0, 1, 0, 0, 0, 24);
        addVec(4'd2, 1, 0, 1, 0, 0, 0, 25);
        addVec(4'd3, 1, 1, 1, 0, 1, 0, 26);
        addVec(4'd7, 1, 1, 0, 1, 0, 1, 26);
        addVec(4'd8, 1, 1, 0, 0, 0, 1, 26);
        addVec(4'd9, 1, 1, 1, 0, 0, 1, 27);

        rst = 1'b0; clr = 1'b0; clk_d = 1'b0; counter = 4'd0;
        repeat (2) @(negedge clk);
        checkField("reset.dir",      32'(dir), 0);
        checkField("reset.locked",   32'(locked), 0);
        checkField("reset.err",      32'(err), 0);
        checkField("reset.dir_chg",  32'(dir_chg), 0);
        checkField("reset.err_cnt",  32'(err_cnt), 0);
        checkField("reset.step_cnt", 32'(step_cnt), 0);
        checkField("reset.last_val", 32'(last_val), 0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].val, vecs[i].low);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // repeated samples force errors, each followed by a two-step relock
        cur = 4'd9;
        exp_ec = 8'd1;
        for (int k = 0; k < 300; k++) begin
            applyStimulus(cur, 1);
            if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
            checkField("sat.err_cnt", 32'(err_cnt), 32'(exp_ec));
            applyStimulus(cur + 4'd1, 1);
            applyStimulus(cur + 4'd2, 1);
            checkField("sat.relock", 32'(locked), 1);
            cur = cur + 4'd2;
        end
        checkField("sat.final", 32'(err_cnt), 255);

        // asynchronous reset in the middle of a clock phase
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkField("arst.locked",   32'(locked), 0);
        checkField("arst.dir",      32'(dir), 0);
        checkField("arst.err_cnt",  32'(err_cnt), 0);
        checkField("arst.step_cnt", 32'(step_cnt), 0);
        checkField("arst.last_val", 32'(last_val), 0);
        counter = 4'd6;
        clk_d   = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkField("release.last_val", 32'(last_val), 6);
        counter = 4'd7;
        @(negedge clk);
        checkField("hold.last_val", 32'(last_val), 6);
        clk_d = 1'b0;
        applyStimulus(4'd7, 1);
        checkField("reacq.locked", 32'(locked), 0);
        applyStimulus(4'd8, 1);
        checkField("relock.locked", 32'(locked), 1);

        // clear coinciding with a sample
        @(negedge clk);
        counter = 4'd9;
        clk_d   = 1'b1;
        clr     = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
        clk_d = 1'b0;
        checkField("clr.last_val", 32'(last_val), 0);
        checkField("clr.locked",   32'(locked), 0);
        checkField("clr.step_cnt", 32'(step_cnt), 0);
        checkField("clr.dir",      32'(dir), 0);
        applyStimulus(4'd1, 1);
        checkField("empty.last_val", 32'(last_val), 1);
        checkField("empty.locked",   32'(locked), 0);
        applyStimulus(4'd2, 1);
        checkField("empty.acq",      32'(locked), 0);
        applyStimulus(4'd3, 1);
        checkField("empty.lock",     32'(locked), 1);
        checkField("empty.dir",      32'(dir), 1);
        checkField("empty.step_cnt", 32'(step_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/count_sequence_checker.md
# count_sequence_checker

Receive-side companion to the up/down counter with clock divider. It observes the counter bus and the divided clock `clk_d` from inside the fast `clk` domain and samples the bus on each rising edge of `clk_d`. From successive samples it infers the counting direction, locks onto a valid ±1 sequence and flags every illegal step. It sits beside the counter as an on-chip sequence monitor and exposes direction, lock, error and step statistics to the rest of the design.

## Interface
Parameters:
- `WIDTH`, 4: counter bus width in bits.
- `LOCK_CNT`, 2: consecutive same-direction ±1 steps required to assert lock (range 1..7).
- `ERR_W`, 8: width of the saturating error counter.
- `STEP_W`, 16: width of the wrapping valid-step counter.

Ports:
- `clk`  in  1: single system clock; all logic is on its rising edge.
- `rst`  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `clr`  in  1: synchronous clear. Same effect as reset, applied on the next `clk` edge.
- `clk_d`  in  1: divided clock, synchronous to `clk` and high/low for at least 1 `clk` cycle each.
- `counter`  in  WIDTH: counter value, stable whenever `clk_d` rises.
- `dir`  out  1: inferred direction. 1 = up, 0 = down. Meaningful only while `locked`=1.
- `locked`  out  1: valid sequence tracking is established.
- `err`  out  1: one-cycle pulse on an illegal step.
- `dir_chg`  out  1: one-cycle pulse when a locked sequence reverses direction.
- `err_cnt`  out  ERR_W: number of `err` pulses, saturating at all-ones.
- `step_cnt`  out  STEP_W: number of valid ±1 steps taken while locked, wrapping.
- `last_val`  out  WIDTH: most recently sampled counter value.

## Operation
- Edge detect: `clk_d_q` is `clk_d` registered. `smp = clk_d & ~clk_d_q`. On a cycle where `smp`=1, `counter` is captured.
- Step: `delta = (counter - last_val) mod 2^WIDTH`. `delta==1` is UP; `delta==2^WIDTH-1` is DOWN. Every other value, including 0, is ILLEGAL. Wrap-around is legal: 15→0 is UP and 0→15 is DOWN when WIDTH=4.
- FSM states are EMPTY, ACQ and TRACK. A 3-bit consistency counter `cons` and a candidate direction `cand` support acquisition.
  - EMPTY: on `smp`, store `last_val` and go to ACQ. No flags are raised.
  - ACQ: on `smp` with UP or DOWN:
    - If `cons`=0 or the step matches `cand`: set `cand` to the step direction and increment `cons`.
    - Otherwise: set `cand` to the step direction and set `cons`=1.
    - When `cons` reaches LOCK_CNT: go to TRACK, set `dir=cand`, assert `locked`.
  - ACQ: on `smp` with ILLEGAL, set `cons`=0. No `err` is raised during acquisition.
  - TRACK: on `smp`:
    - Step equals `dir`: increment `step_cnt`.
    - Step is the opposite direction: flip `dir`, pulse `dir_chg`, increment `step_cnt`, stay in TRACK.
    - ILLEGAL: pulse `err`, increment `err_cnt` (saturating), drop `locked`, set `cons`=0, go to ACQ.
- `last_val` updates on every `smp` in every state.
- `clr` or `rst` returns the block to EMPTY. `clr` has priority over a simultaneous `smp`, and that sample is discarded.

## Timing
- Reset values: `dir`=0, `locked`=0, `err`=0, `dir_chg`=0, `err_cnt`=0, `step_cnt`=0, `last_val`=0, `clk_d_q`=0, `cons`=0, state=EMPTY.
- Latency:
  - A rising edge of `clk_d` registered at edge N produces `smp` during cycle N.
  - All resulting output updates are visible after edge N+1.
  - `err` and `dir_chg` are high for exactly that one cycle.
- Lock timing: `locked` rises one cycle after the LOCK_CNT-th consistent sample, i.e. the (LOCK_CNT+1)-th sample overall from EMPTY.
- Reset mid-operation: outputs go to their reset values immediately and asynchronously. `clk_d_q`=0 on release, so a `clk_d` that is already high at release produces `smp` on the first edge.
- Saturation: `err_cnt` holds at 2^ERR_W-1. `step_cnt` wraps from 2^STEP_W-1 to 0.
- No `smp` occurs while `clk_d` is held constant. All outputs then hold their values.

## Test plan
- Up count:
  - Stimulus: `clk_d` period 4 `clk`; `counter` 0,1,2,...,15,0,1.
  - Response: `locked`=1 after the 3rd sample; `dir`=1; no `err` at the 15→0 wrap; `step_cnt`=16 after the final sample.
- Reversal:
  - Stimulus: locked up at 5; then samples 6,5,4.
  - Response: single `dir_chg` pulse after the sample of 5; `dir`=0; `locked` stays 1; `err_cnt`=0.
- Illegal step:
  - Stimulus: locked up at 3; then samples 7,8,9.
  - Response: `err` pulse and `locked`=0 after the 7; `err_cnt`=1; relock (`locked`=1, `dir`=1) after the 9.
- Stall and saturation:
  - Stimulus: locked; then 300 repeated equal samples interleaved with relocks.
  - Response: `err_cnt` stops at 255 and never wraps.
- Reset and clear:
  - Stimulus: assert `rst`=0 mid-TRACK between `clk` edges; later pulse `clr` in the same cycle as `smp`.
  - Response: all outputs zero immediately on `rst`; with `clr`, the block is in EMPTY and the sample is discarded (`last_val`=0).
